// File: rtl/uart_rx_cmd_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_ctrl_pkg
// Brief   : Command codes, FSM state type and operand addresses shared by the
//           UART command-frame controller and its bench.
// Rev     : 1.0 - initial release
// ============================================================================
package uart_ctrl_pkg;

    localparam logic [7:0] CMD_RF_WR   = 8'hAA;
    localparam logic [7:0] CMD_RF_RD   = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    localparam int OPA_ADDR = 0;
    localparam int OPB_ADDR = 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_ADDR = 3'd1,
        ST_WR_DATA = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_OP_A    = 3'd4,
        ST_OP_B    = 3'd5,
        ST_ALU_FUN = 3'd6
    } state_t;

    // Unknown command codes map to ST_IDLE, which the caller treats as a reject.
    function automatic state_t cmd_to_state(input logic [7:0] code);
        case (code)
            CMD_RF_WR:   return ST_WR_ADDR;
            CMD_RF_RD:   return ST_RD_ADDR;
            CMD_ALU_OP:  return ST_OP_A;
            CMD_ALU_NOP: return ST_ALU_FUN;
            default:     return ST_IDLE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_cmd_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_cmd_ctrl_if
// Brief   : Byte stream from the UART RX plus register-file / ALU command side.
// Rev     : 1.0 - initial release
// ============================================================================
interface uart_rx_cmd_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic [DATA_WIDTH-1:0] rx_p_data;
    logic                  rx_data_valid;
    logic                  rx_parity_error;
    logic                  rx_framing_error;

    logic                  rf_wr_en;
    logic                  rf_rd_en;
    logic [ADDR_WIDTH-1:0] rf_addr;
    logic [DATA_WIDTH-1:0] rf_wr_data;
    logic                  alu_en;
    logic [3:0]            alu_fun;
    logic                  busy;
    logic                  cmd_error;

    modport master (
        output rx_p_data, rx_data_valid, rx_parity_error, rx_framing_error,
        input  rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_fun,
               busy, cmd_error
    );

    modport slave (
        input  rx_p_data, rx_data_valid, rx_parity_error, rx_framing_error,
        output rf_wr_en, rf_rd_en, rf_addr, rf_wr_data, alu_en, alu_fun,
               busy, cmd_error
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_cmd_ctrl_timeout.sv
`default_nettype none
// ============================================================================
// Module  : cmd_timeout_cnt
// Brief   : Idle-cycle counter that flags an abandoned partial frame.
// Rev     : 1.0 - initial release
// ============================================================================
module cmd_timeout_cnt #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd65535
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic busy,
    input  wire logic strobe,
    output logic      expired
);
    logic [15:0] r_cnt;

    // A strobe in the expiry cycle wins, so it masks the abort.
    assign expired = busy && !strobe && (r_cnt == TIMEOUT_CYCLES - 16'd1);

    always_ff @(posedge clk) begin
        if (rst || strobe || expired || !busy) begin
            r_cnt <= 16'd0;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end
endmodule
`default_nettype wire

// File: rtl/uart_rx_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_cmd_ctrl
// Brief   : Decodes UART byte frames into register-file and ALU commands.
//           Optional partial-frame timeout enabled by CMD_TIMEOUT_EN.
// Rev     : 1.0 - initial release
// ============================================================================
module uart_rx_cmd_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
`ifdef CMD_TIMEOUT_EN
    ,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd65535
`endif
) (
    input  wire logic          clk,
    input  wire logic          rst,
    uart_rx_cmd_ctrl_if.slave  bus
);
    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_wr_en, r_rd_en, r_alu_en, r_cmd_error;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic [3:0]            r_alu_fun;

    logic                  w_wr_en, w_rd_en, w_alu_en, w_cmd_error;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic [3:0]            w_alu_fun;

    logic   w_busy;
    logic   w_acc;
    logic   w_err_byte;
    logic   w_timeout;
    state_t w_cmd_state;

    assign w_busy      = (r_state != ST_IDLE);
    assign w_acc       = bus.rx_data_valid && !bus.rx_parity_error && !bus.rx_framing_error;
    assign w_err_byte  = bus.rx_data_valid && (bus.rx_parity_error || bus.rx_framing_error);
    assign w_cmd_state = cmd_to_state(bus.rx_p_data[7:0]);

`ifdef CMD_TIMEOUT_EN
    cmd_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .busy    (w_busy),
        .strobe  (bus.rx_data_valid),
        .expired (w_timeout)
    );
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_wr_en     <= 1'b0;
            r_rd_en     <= 1'b0;
            r_alu_en    <= 1'b0;
            r_cmd_error <= 1'b0;
            r_addr      <= '0;
            r_wr_data   <= '0;
            r_alu_fun   <= 4'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_wr_en     <= w_wr_en;
            r_rd_en     <= w_rd_en;
            r_alu_en    <= w_alu_en;
            r_cmd_error <= w_cmd_error;
            r_addr      <= w_addr;
            r_wr_data   <= w_wr_data;
            r_alu_fun   <= w_alu_fun;
        end
    end

    // An errored byte overrides whatever the byte would otherwise have done.
    always_comb begin
        w_state_nxt = r_state;
        if (w_err_byte) begin
            w_state_nxt = ST_IDLE;
        end else if (w_acc) begin
            case (r_state)
                ST_IDLE:    w_state_nxt = w_cmd_state;
                ST_WR_ADDR: w_state_nxt = ST_WR_DATA;
                ST_OP_A:    w_state_nxt = ST_OP_B;
                ST_OP_B:    w_state_nxt = ST_ALU_FUN;
                default:    w_state_nxt = ST_IDLE;
            endcase
        end else if (w_timeout) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_comb begin
        w_wr_en     = 1'b0;
        w_rd_en     = 1'b0;
        w_alu_en    = 1'b0;
        w_cmd_error = 1'b0;
        w_addr      = r_addr;
        w_wr_data   = r_wr_data;
        w_alu_fun   = r_alu_fun;
        if (w_err_byte) begin
            w_cmd_error = 1'b1;
        end else if (w_acc) begin
            case (r_state)
                ST_IDLE: begin
                    w_cmd_error = (w_cmd_state == ST_IDLE);
                end
                ST_WR_ADDR: begin
                    w_addr = bus.rx_p_data[ADDR_WIDTH-1:0];
                end
                ST_WR_DATA: begin
                    w_wr_data = bus.rx_p_data;
                    w_wr_en   = 1'b1;
                end
                ST_RD_ADDR: begin
                    w_addr  = bus.rx_p_data[ADDR_WIDTH-1:0];
                    w_rd_en = 1'b1;
                end
                ST_OP_A: begin
                    w_addr    = ADDR_WIDTH'(OPA_ADDR);
                    w_wr_data = bus.rx_p_data;
                    w_wr_en   = 1'b1;
                end
                ST_OP_B: begin
                    w_addr    = ADDR_WIDTH'(OPB_ADDR);
                    w_wr_data = bus.rx_p_data;
                    w_wr_en   = 1'b1;
                end
                ST_ALU_FUN: begin
                    w_alu_fun = bus.rx_p_data[3:0];
                    w_alu_en  = 1'b1;
                end
                default: begin
                    w_cmd_error = 1'b1;
                end
            endcase
        end else if (w_timeout) begin
            w_cmd_error = 1'b1;
        end
    end

    assign bus.rf_wr_en   = r_wr_en;
    assign bus.rf_rd_en   = r_rd_en;
    assign bus.alu_en     = r_alu_en;
    assign bus.cmd_error  = r_cmd_error;
    assign bus.rf_addr    = r_addr;
    assign bus.rf_wr_data = r_wr_data;
    assign bus.alu_fun    = r_alu_fun;
    assign bus.busy       = w_busy;

endmodule
`default_nettype wire
